alu4_seq_ctrl: RTL and testbench

- Multi-cycle controller that runs W = 4*NIBBLES-bit operations through one shared combinational 4-bit ALU slice, one nibble per cycle, LSB nibble first.
- Accepts commands on a valid/ready handshake and drives the ALU operand, function and carry-in pins.
- Accumulates the per-nibble results and returns the full-width result and flags on a second valid/ready handshake.
- Sits between the instruction decode logic and the 4-bit ALU.

---
 rtl/alu4_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu4_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_seq_ctrl.sv
// Nibble-serial controller that runs W = 4*NIBBLES-bit operations through one external 4-bit ALU slice.
// Optional build macro ALU_SEQ_SAT_EN: ADD/SUB results saturate on signed overflow.
module alu4_seq_ctrl #(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [4*NIBBLES-1:0]   cmd_a,
  input  logic [4*NIBBLES-1:0]   cmd_b,
  input  logic                   cmd_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_overflow,
  output logic                   rsp_zero,
  output logic                   rsp_flag,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_c,
  output logic                   alu_cin,
  input  logic [3:0]             alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_overflow,
  output logic [1:0]             dbg_state
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_SEQ = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // rsp_* are held stable from rsp_valid rising until the transfer completes.

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q, b_q, result_q, final_result;
  logic            cin_q, carry_q, fin_carry_q, fin_ovf_q;
  logic [IW-1:0]   idx;
  logic            last_nib, is_arith;
  logic [3:0]      a_nib, b_nib;

  assign dbg_state = state;
  assign last_nib  = (idx == IW'(NIBBLES - 1));
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SEQ);
  assign a_nib     = a_q[4*idx +: 4];
  assign b_nib     = b_q[4*idx +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_c     = 3'b000;
    alu_cin   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) state_nxt = S_RUN;
      end
      S_RUN: begin
        alu_a = a_nib;
        if (is_arith) begin
          // Subtraction and compares are a + ~b + 1 through the adder function.
          alu_c = 3'b000;
          alu_b = (op_q == OP_ADD) ? b_nib : ~b_nib;
          if (idx == '0) alu_cin = (op_q == OP_ADD) ? cin_q : 1'b1;
          else           alu_cin = carry_q;
        end else begin
          alu_b = b_nib;
          case (op_q)
            OP_NOT:  alu_c = 3'b010;
            OP_AND:  alu_c = 3'b011;
            OP_OR:   alu_c = 3'b100;
            default: alu_c = 3'b101;
          endcase
        end
        if (last_nib) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 3'd0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      fin_carry_q <= 1'b0;
      fin_ovf_q   <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            cin_q    <= cmd_cin;
            result_q <= '0;
            idx      <= '0;
          end
        end
        S_RUN: begin
          result_q[4*idx +: 4] <= alu_result;
          carry_q              <= alu_carry;
          if (last_nib) begin
            fin_carry_q <= alu_carry;
            fin_ovf_q   <= alu_overflow;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    final_result = result_q;
`ifdef ALU_SEQ_SAT_EN
    // Clamp toward the sign of a; compares keep the raw difference.
    if ((op_q == OP_ADD || op_q == OP_SUB) && fin_ovf_q)
      final_result = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    rsp_valid    = 1'b0;
    rsp_result   = '0;
    rsp_carry    = 1'b0;
    rsp_overflow = 1'b0;
    rsp_zero     = 1'b0;
    rsp_flag     = 1'b0;
    if (state == S_DONE) begin
      rsp_valid  = 1'b1;
      rsp_result = final_result;
      rsp_zero   = (final_result == '0);
      if (is_arith) begin
        rsp_carry    = fin_carry_q;
        rsp_overflow = fin_ovf_q;
      end
      if (op_q == OP_SLT) rsp_flag = result_q[W-1] ^ fin_ovf_q;
      if (op_q == OP_SEQ) rsp_flag = (result_q == '0);
    end
  end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Self-checking bench for alu4_seq_ctrl: behavioural 4-bit ALU, full-width reference model,
// directed scenarios and randomized commands.
module tb_alu4_seq_ctrl;

  localparam int NIBBLES = 2;
  localparam int W       = 4 * NIBBLES;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, NOT_ = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, SLT = 3'd6, SEQ = 3'd7;

  logic         clk, rst_n;
  logic         cmd_valid, cmd_ready, cmd_cin;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry, rsp_overflow, rsp_zero, rsp_flag;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic [2:0]   alu_c;
  logic         alu_cin, alu_carry, alu_overflow;
  logic [1:0]   dbg_state;
  logic [4:0]   alu_sum;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   flg_q[$];

  alu4_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_flag(rsp_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External 4-bit ALU slice
  always_comb begin
    alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
    alu_result   = 4'h0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_c)
      3'b000: begin
        alu_result   = alu_sum[3:0];
        alu_carry    = alu_sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      3'b010:  alu_result = ~alu_a;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      default: alu_result = 4'h0;
    endcase
  end

  // Full-width reference: returns {result, carry, overflow, zero, flag}
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v, f;
    c = 1'b0; v = 1'b0; f = 1'b0; r = '0;
    case (op)
      ADD: begin
        s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      SUB, SLT, SEQ: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      NOT_: r = ~a;
      AND_: r = a & b;
      OR_:  r = a | b;
      default: r = a ^ b;
    endcase
    if (op == SLT) f = ($signed(a) < $signed(b));
    if (op == SEQ) f = (a == b);
`ifdef ALU_SEQ_SAT_EN
    if ((op == ADD || op == SUB) && v) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {r, c, v, (r == '0), f};
  endfunction

  // Expected ALU pins {alu_a, alu_b, alu_c, alu_cin} while nibble i is processed
  function automatic logic [11:0] exp_pins(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin, input int i);
    logic [W-1:0] bb;
    logic [63:0]  mask, lo;
    logic         c0, ci;
    logic [2:0]   code;
    bb = b; ci = 1'b0; code = 3'b000;
    case (op)
      ADD, SUB, SLT, SEQ: begin
        bb   = (op == ADD) ? b : ~b;
        c0   = (op == ADD) ? cin : 1'b1;
        mask = (64'd1 << (4 * i)) - 64'd1;
        lo   = (64'(a) & mask) + (64'(bb) & mask) + 64'(c0);
        ci   = lo[4*i];
      end
      NOT_: code = 3'b010;
      AND_: code = 3'b011;
      OR_:  code = 3'b100;
      default: code = 3'b101;
    endcase
    return {a[4*i +: 4], bb[4*i +: 4], code, ci};
  endfunction

  // Driver: one command end to end. hold<0 keeps rsp_ready high from accept onward.
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold);
    logic [W+3:0] e;
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic [11:0]  pe;
    int cyc;
    e = model(op, a, b, cin);
    exp_q.push_back(e[W+3:4]);
    flg_q.push_back(e[3:0]);
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    else n_pass++;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_cin = 1'($urandom);
    rsp_ready = (hold < 0);
    for (int i = 0; i < NIBBLES; i++) begin
      pe = exp_pins(op, a, b, cin, i);
      n_checks++;
      if ({alu_a, alu_b, alu_c, alu_cin} !== pe)
        $display("FAIL alu_pins op=%0d nib=%0d: got %h expected %h", op, i,
                 {alu_a, alu_b, alu_c, alu_cin}, pe);
      else n_pass++;
      n_checks++;
      if ({rsp_valid, cmd_ready} !== 2'b00)
        $display("FAIL run_busy nib=%0d: got %b expected 00", i, {rsp_valid, cmd_ready});
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL latency: rsp_valid got %b expected 1 at %0d cycles", rsp_valid, NIBBLES + 1);
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    end else n_pass++;
    er = exp_q.pop_front();
    ef = flg_q.pop_front();
    n_checks++;
    if (rsp_result !== er)
      $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, rsp_result, er);
    else n_pass++;
    n_checks++;
    if ({rsp_carry, rsp_overflow, rsp_zero, rsp_flag} !== ef)
      $display("FAIL flags op=%0d a=%h b=%h: got %b expected %b (c,v,z,f)", op, a, b,
               {rsp_carry, rsp_overflow, rsp_zero, rsp_flag}, ef);
    else n_pass++;
    // While the response is pending, offer a competing command that must be ignored.
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_op = 3'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_flag, cmd_ready} !==
          {1'b1, er, ef, 1'b0})
        $display("FAIL hold_stable cyc=%0d: got %h expected %h", h,
                 {rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_flag, cmd_ready},
                 {1'b1, er, ef, 1'b0});
      else n_pass++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL handshake_done: got %b expected 01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0;
    cmd_cin = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_flag,
         alu_a, alu_b, alu_c, alu_cin} !== '0)
      $display("FAIL reset_outputs: got nonzero %b cmd_ready/rsp_valid", {cmd_ready, rsp_valid});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10)
      $display("FAIL reset_release: got %b expected 10", {cmd_ready, rsp_valid});
    else n_pass++;
  endtask

  task automatic test_add;
    do_cmd(ADD, 8'h7F, 8'h01, 1'b0, 0);
    do_cmd(ADD, 8'hFF, 8'h01, 1'b0, 0);
    do_cmd(ADD, 8'hFF, 8'hFF, 1'b1, 0);
  endtask

  task automatic test_sub;
    do_cmd(SUB, 8'h10, 8'h01, 1'b0, 0);
    do_cmd(SUB, 8'h80, 8'h01, 1'b1, 0);
    do_cmd(SUB, 8'h00, 8'h01, 1'b0, 0);
  endtask

  task automatic test_slt_seq;
    do_cmd(SLT, 8'hFE, 8'h01, 1'b0, 0);
    do_cmd(SLT, 8'h01, 8'hFE, 1'b0, 0);
    do_cmd(SLT, 8'h80, 8'h7F, 1'b0, 0);
    do_cmd(SEQ, 8'h5A, 8'h5A, 1'b0, 0);
    do_cmd(SEQ, 8'h5A, 8'h5B, 1'b0, 0);
  endtask

  task automatic test_logic;
    do_cmd(XOR_, 8'hF0, 8'hFF, 1'b1, 0);
    do_cmd(NOT_, 8'h00, W'($urandom), 1'b1, 0);
    do_cmd(AND_, 8'hC3, 8'h5A, 1'b0, 0);
    do_cmd(OR_,  8'hC3, 8'h5A, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    do_cmd(ADD, 8'h3C, 8'h44, 1'b1, 5);
    do_cmd(SUB, 8'h44, 8'h3C, 1'b0, -1);
    do_cmd(SLT, 8'h05, 8'h06, 1'b0, -1);
  endtask

  // Reset asserted 'extra' cycles after the first RUN cycle; no response may appear.
  task automatic test_abort(input int extra);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_a = 8'h12; cmd_b = 8'h34; cmd_cin = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < extra; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_flag,
         alu_a, alu_b, alu_c, alu_cin} !== '0)
      $display("FAIL abort_outputs extra=%0d: got cmd_ready/rsp_valid %b, nonzero outputs",
               extra, {cmd_ready, rsp_valid});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10)
      $display("FAIL abort_release extra=%0d: got %b expected 10", extra, {cmd_ready, rsp_valid});
    else n_pass++;
    do_cmd(ADD, 8'h01, 8'h01, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [2:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      do_cmd(op, W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 4)) - 1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt_seq();
    test_logic();
    test_backpressure();
    test_abort(1);
    test_abort(2);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
